// File: rtl/charge_accum_ram.sv
// Dual-port charge RAM with signed saturating accumulate, read-and-clear and hardware zero-sweep.
// Two-stage pipeline (issue / execute) over a 1R1W array, forwarding the last write for back-to-back same-address ops.
module charge_accum_ram #(
  parameter  int WIDTH = 16,
  parameter  int DEPTH = 256,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear_all,
  output logic             busy,
  input  logic             acc_valid,
  output logic             acc_ready,
  input  logic [AW-1:0]    acc_addr,
  input  logic [WIDTH-1:0] acc_delta,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  input  logic             rd_clear,
  output logic             rd_valid,
  output logic [WIDTH-1:0] rd_data
);

  typedef enum logic [0:0] {SWEEP = 1'b0, RUN = 1'b1} state_t;

  function automatic logic [WIDTH-1:0] sat_add(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [WIDTH:0] s;
    s = {a[WIDTH-1], a} + {b[WIDTH-1], b};
    if (s[WIDTH] != s[WIDTH-1]) begin
      sat_add = s[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      sat_add = s[WIDTH-1:0];
    end
  endfunction

  logic [WIDTH-1:0] mem [DEPTH];

  state_t           state_r, state_next_s;
  logic [AW-1:0]    sweep_ptr_r, sweep_ptr_next_s;
  logic             run_s, issue_rd_s, issue_acc_s;
  logic [AW-1:0]    s0_addr_s;
  logic             s1_valid_r, s1_is_rd_r, s1_clr_r;
  logic [AW-1:0]    s1_addr_r;
  logic [WIDTH-1:0] s1_delta_r;
  logic             fwd_hit_r;
  logic [WIDTH-1:0] fwd_data_r, mem_q_r, operand_s, s1_wdata_s, rd_hold_r;
  logic             s1_wen_s, mem_we_s;
  logic [AW-1:0]    mem_waddr_s;
  logic [WIDTH-1:0] mem_wdata_s;

  // Next-state logic: sweep walks every address once, clear_all from RUN restarts it
  always_comb begin
    state_next_s     = state_r;
    sweep_ptr_next_s = sweep_ptr_r;
    case (state_r)
      SWEEP: begin
        if (sweep_ptr_r == AW'(DEPTH - 1)) begin
          state_next_s     = RUN;
          sweep_ptr_next_s = {AW{1'b0}};
        end else begin
          sweep_ptr_next_s = sweep_ptr_r + AW'(1'b1);
        end
      end
      RUN: begin
        if (clear_all) begin
          state_next_s     = SWEEP;
          sweep_ptr_next_s = {AW{1'b0}};
        end else begin
          state_next_s     = RUN;
        end
      end
      default: begin
        state_next_s     = SWEEP;
        sweep_ptr_next_s = {AW{1'b0}};
      end
    endcase
  end

  // State and sweep pointer registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= SWEEP;
      sweep_ptr_r <= {AW{1'b0}};
    end else begin
      state_r     <= state_next_s;
      sweep_ptr_r <= sweep_ptr_next_s;
    end
  end

  // Issue arbitration: reads win the shared read port; a clear_all cycle issues nothing
  always_comb begin
    run_s       = (state_r == RUN);
    issue_rd_s  = run_s & ~clear_all & rd_en;
    issue_acc_s = run_s & ~clear_all & ~rd_en & acc_valid;
    s0_addr_s   = rd_en ? rd_addr : acc_addr;
    busy        = ~run_s;
    acc_ready   = run_s & ~rd_en;
  end

  // Execute stage: operand comes from the previous write when it hit the same address
  always_comb begin
    operand_s  = fwd_hit_r ? fwd_data_r : mem_q_r;
    s1_wen_s   = s1_valid_r & (~s1_is_rd_r | s1_clr_r);
    s1_wdata_s = s1_is_rd_r ? {WIDTH{1'b0}} : sat_add(operand_s, s1_delta_r);
    rd_valid   = s1_valid_r & s1_is_rd_r;
    rd_data    = rd_valid ? operand_s : rd_hold_r;
    if (state_r == SWEEP) begin
      mem_we_s    = 1'b1;
      mem_waddr_s = sweep_ptr_r;
      mem_wdata_s = {WIDTH{1'b0}};
    end else begin
      mem_we_s    = s1_wen_s;
      mem_waddr_s = s1_addr_r;
      mem_wdata_s = s1_wdata_s;
    end
  end

  // Pipeline registers; reset empties stage 1 so an in-flight write never lands
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid_r <= 1'b0;
      s1_is_rd_r <= 1'b0;
      s1_clr_r   <= 1'b0;
      s1_addr_r  <= {AW{1'b0}};
      s1_delta_r <= {WIDTH{1'b0}};
      fwd_hit_r  <= 1'b0;
      fwd_data_r <= {WIDTH{1'b0}};
      rd_hold_r  <= {WIDTH{1'b0}};
    end else begin
      s1_valid_r <= issue_rd_s | issue_acc_s;
      s1_is_rd_r <= issue_rd_s;
      s1_clr_r   <= issue_rd_s & rd_clear;
      s1_addr_r  <= s0_addr_s;
      s1_delta_r <= acc_delta;
      fwd_hit_r  <= s1_wen_s & (s1_addr_r == s0_addr_s);
      fwd_data_r <= s1_wdata_s;
      rd_hold_r  <= rd_data;
    end
  end

  // Storage array: synchronous read, single write port, no reset
  always_ff @(posedge clk) begin
    mem_q_r <= mem[s0_addr_s];
    if (mem_we_s) begin
      mem[mem_waddr_s] <= mem_wdata_s;
    end
  end

endmodule

// File: tb/tb_charge_accum_ram.sv
// Bench for charge_accum_ram: directed scenarios plus randomized traffic checked against
// a sequential array model with saturating arithmetic.
module tb_charge_accum_ram;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        clear_all = 1'b0;
  logic        busy;
  logic        acc_valid = 1'b0;
  logic        acc_ready;
  logic [7:0]  acc_addr = 8'd0;
  logic [15:0] acc_delta = 16'd0;
  logic        rd_en = 1'b0;
  logic [7:0]  rd_addr = 8'd0;
  logic        rd_clear = 1'b0;
  logic        rd_valid;
  logic [15:0] rd_data;

  charge_accum_ram #(.WIDTH(16), .DEPTH(256)) dut (
    .clk(clk), .reset(reset), .clear_all(clear_all), .busy(busy),
    .acc_valid(acc_valid), .acc_ready(acc_ready), .acc_addr(acc_addr), .acc_delta(acc_delta),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_clear(rd_clear), .rd_valid(rd_valid), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  int          vectors = 0;
  int          miscompares = 0;
  int          model [256];
  logic        pend_valid = 1'b0;
  logic [15:0] hold_exp = 16'd0;
  logic        last_acc_ready = 1'b0;

  function automatic int sat(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_zero();
    for (int i = 0; i < 256; i++) model[i] = 0;
  endtask

  // Drive one cycle of requests, update the model in issue order, return one cycle later
  task automatic issue(input bit do_rd, input bit clr, input int raddr, input bit do_acc, input int aaddr, input int delta);
    int cur;
    rd_en = do_rd; rd_clear = clr; rd_addr = 8'(raddr);
    acc_valid = do_acc; acc_addr = 8'(aaddr); acc_delta = 16'(delta);
    #1;
    last_acc_ready = acc_ready;
    pend_valid = do_rd;
    if (do_rd) begin
      cur = model[raddr];
      hold_exp = 16'(cur);
      if (clr) model[raddr] = 0;
    end else if (do_acc) begin
      model[aaddr] = sat(model[aaddr] + delta);
    end
    @(posedge clk);
    #1;
    rd_en = 1'b0; rd_clear = 1'b0; acc_valid = 1'b0;
  endtask

  // Counts busy cycles while hammering the request inputs; bad counts any leak of ready/valid
  task automatic count_busy(output int cnt, output int bad);
    cnt = 0; bad = 0;
    while (busy === 1'b1 && cnt < 2000) begin
      acc_valid = 1'b1; acc_addr = 8'($urandom); acc_delta = 16'($urandom);
      rd_en = 1'($urandom_range(0, 1)); rd_addr = 8'($urandom);
      #1;
      if (acc_ready !== 1'b0 || rd_valid !== 1'b0) bad++;
      cnt++;
      @(posedge clk);
      #1;
    end
    acc_valid = 1'b0; rd_en = 1'b0;
  endtask

  task automatic test_reset();
    int cnt, bad;
    reset = 1'b0;
    acc_valid = 1'b1;
    step(); step(); step();
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL reset_busy: got %b expected 1", busy); end
    vectors++; if (acc_ready !== 1'b0) begin miscompares++; $display("FAIL reset_acc_ready: got %b expected 0", acc_ready); end
    vectors++; if (rd_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rd_valid: got %b expected 0", rd_valid); end
    vectors++; if (rd_data !== 16'h0000) begin miscompares++; $display("FAIL reset_rd_data: got %h expected 0000", rd_data); end
    acc_valid = 1'b0;
    reset = 1'b1;
    hold_exp = 16'd0; pend_valid = 1'b0;
    count_busy(cnt, bad);
    model_zero();
    vectors++; if (cnt != 256) begin miscompares++; $display("FAIL reset_sweep_len: got %0d expected 256", cnt); end
    vectors++; if (bad != 0) begin miscompares++; $display("FAIL reset_sweep_quiet: got %0d leaks expected 0", bad); end
    for (int a = 0; a < 256; a++) begin
      issue(1'b1, 1'b0, a, 1'b0, 0, 0);
      vectors++;
      if (rd_valid !== 1'b1 || rd_data !== 16'h0000) begin
        miscompares++; $display("FAIL reset_zero[%0d]: got valid=%b data=%h expected valid=1 data=0000", a, rd_valid, rd_data);
      end
    end
  endtask

  task automatic test_back_to_back();
    issue(1'b0, 1'b0, 0, 1'b1, 7, 3);
    vectors++; if (last_acc_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_ready: got %b expected 1", last_acc_ready); end
    issue(1'b0, 1'b0, 0, 1'b1, 7, 5);
    issue(1'b0, 1'b0, 0, 1'b1, 7, -2);
    issue(1'b1, 1'b0, 7, 1'b0, 0, 0);
    vectors++;
    if (rd_valid !== 1'b1 || rd_data !== 16'd6) begin
      miscompares++; $display("FAIL b2b_read: got valid=%b data=%h expected valid=1 data=0006", rd_valid, rd_data);
    end
    step();
    vectors++; if (rd_valid !== 1'b0 || rd_data !== 16'd6) begin
      miscompares++; $display("FAIL b2b_hold: got valid=%b data=%h expected valid=0 data=0006", rd_valid, rd_data);
    end
  endtask

  task automatic test_saturation();
    issue(1'b0, 1'b0, 0, 1'b1, 1, 32767);
    issue(1'b0, 1'b0, 0, 1'b1, 1, 10);
    issue(1'b0, 1'b0, 0, 1'b1, 2, -32768);
    issue(1'b0, 1'b0, 0, 1'b1, 2, -1);
    issue(1'b1, 1'b0, 1, 1'b0, 0, 0);
    vectors++; if (rd_data !== 16'h7FFF) begin miscompares++; $display("FAIL sat_pos: got %h expected 7fff", rd_data); end
    issue(1'b1, 1'b0, 2, 1'b0, 0, 0);
    vectors++; if (rd_data !== 16'h8000) begin miscompares++; $display("FAIL sat_neg: got %h expected 8000", rd_data); end
  endtask

  task automatic test_read_clear();
    issue(1'b0, 1'b0, 0, 1'b1, 9, 40);
    step();
    issue(1'b1, 1'b1, 9, 1'b0, 0, 0);
    vectors++; if (rd_valid !== 1'b1 || rd_data !== 16'd40) begin
      miscompares++; $display("FAIL rdclr_value: got valid=%b data=%h expected valid=1 data=0028", rd_valid, rd_data);
    end
    issue(1'b0, 1'b0, 0, 1'b1, 9, 4);
    step();
    issue(1'b1, 1'b1, 9, 1'b0, 0, 0);
    vectors++; if (rd_data !== 16'd4) begin miscompares++; $display("FAIL rdclr_after_acc: got %h expected 0004", rd_data); end
    issue(1'b1, 1'b0, 9, 1'b0, 0, 0);
    vectors++; if (rd_data !== 16'd0) begin miscompares++; $display("FAIL rdclr_then_read: got %h expected 0000", rd_data); end
  endtask

  task automatic test_arbitration();
    for (int i = 0; i < 3; i++) begin
      issue(1'b1, 1'b0, 20, 1'b1, 30, 11);
      vectors++; if (last_acc_ready !== 1'b0) begin miscompares++; $display("FAIL arb_blocked[%0d]: got %b expected 0", i, last_acc_ready); end
      vectors++; if (rd_valid !== 1'b1 || rd_data !== 16'd0) begin
        miscompares++; $display("FAIL arb_read[%0d]: got valid=%b data=%h expected valid=1 data=0000", i, rd_valid, rd_data);
      end
    end
    issue(1'b0, 1'b0, 0, 1'b1, 30, 11);
    vectors++; if (last_acc_ready !== 1'b1) begin miscompares++; $display("FAIL arb_accept: got %b expected 1", last_acc_ready); end
    issue(1'b1, 1'b0, 30, 1'b0, 0, 0);
    vectors++; if (rd_data !== 16'd11) begin miscompares++; $display("FAIL arb_result: got %h expected 000b", rd_data); end
  endtask

  task automatic test_random();
    bit do_rd, clr, do_acc;
    int ra, aa, d;
    for (int n = 0; n < 2000; n++) begin
      do_rd  = ($urandom_range(0, 2) == 0);
      clr    = 1'($urandom_range(0, 1));
      do_acc = ($urandom_range(0, 3) != 0);
      ra = $urandom_range(0, 7);
      aa = $urandom_range(0, 7);
      case ($urandom_range(0, 3))
        0:       d = int'($urandom_range(0, 65535)) - 32768;
        1:       d = ($urandom_range(0, 1) == 1) ? 32767 : -32768;
        default: d = int'($urandom_range(0, 200)) - 100;
      endcase
      issue(do_rd, clr, ra, do_acc, aa, d);
      vectors++; if (last_acc_ready !== !do_rd) begin miscompares++; $display("FAIL rnd_ready[%0d]: got %b expected %b", n, last_acc_ready, !do_rd); end
      vectors++; if (rd_valid !== pend_valid) begin miscompares++; $display("FAIL rnd_valid[%0d]: got %b expected %b", n, rd_valid, pend_valid); end
      vectors++; if (rd_data !== hold_exp) begin miscompares++; $display("FAIL rnd_data[%0d]: got %h expected %h", n, rd_data, hold_exp); end
    end
    for (int a = 0; a < 8; a++) begin
      issue(1'b1, 1'b0, a, 1'b0, 0, 0);
      vectors++; if (rd_data !== hold_exp) begin miscompares++; $display("FAIL rnd_final[%0d]: got %h expected %h", a, rd_data, hold_exp); end
    end
  endtask

  task automatic test_clear_all();
    int cnt, bad;
    for (int i = 0; i < 16; i++) issue(1'b0, 1'b0, 0, 1'b1, i, 1000 + i);
    issue(1'b0, 1'b0, 0, 1'b1, 3, 55);
    clear_all = 1'b1; rd_en = 1'b1; rd_addr = 8'd5;
    step();
    clear_all = 1'b0; rd_en = 1'b0;
    vectors++; if (rd_valid !== 1'b0) begin miscompares++; $display("FAIL clr_rd_dropped: got %b expected 0", rd_valid); end
    count_busy(cnt, bad);
    model_zero();
    vectors++; if (cnt != 256) begin miscompares++; $display("FAIL clr_sweep_len: got %0d expected 256", cnt); end
    vectors++; if (bad != 0) begin miscompares++; $display("FAIL clr_sweep_quiet: got %0d leaks expected 0", bad); end
    for (int a = 0; a < 256; a++) begin
      issue(1'b1, 1'b0, a, 1'b0, 0, 0);
      vectors++; if (rd_valid !== 1'b1 || rd_data !== 16'h0000) begin
        miscompares++; $display("FAIL clr_zero[%0d]: got valid=%b data=%h expected valid=1 data=0000", a, rd_valid, rd_data);
      end
    end
  endtask

  task automatic test_reset_mid_sweep();
    int cnt, bad;
    issue(1'b0, 1'b0, 0, 1'b1, 12, 77);
    issue(1'b1, 1'b0, 12, 1'b0, 0, 0);
    vectors++; if (rd_data !== 16'd77) begin miscompares++; $display("FAIL mid_pre_read: got %h expected 004d", rd_data); end
    clear_all = 1'b1;
    step();
    clear_all = 1'b0;
    for (int i = 0; i < 100; i++) step();
    reset = 1'b0;
    step(); step();
    vectors++; if (busy !== 1'b1 || acc_ready !== 1'b0 || rd_valid !== 1'b0 || rd_data !== 16'h0000) begin
      miscompares++; $display("FAIL mid_reset_state: got busy=%b ready=%b valid=%b data=%h expected 1 0 0 0000", busy, acc_ready, rd_valid, rd_data);
    end
    reset = 1'b1;
    hold_exp = 16'd0;
    count_busy(cnt, bad);
    model_zero();
    vectors++; if (cnt != 256) begin miscompares++; $display("FAIL mid_sweep_len: got %0d expected 256", cnt); end
    for (int i = 0; i < 8; i++) begin
      issue(1'b1, 1'b0, (i == 0) ? 12 : int'($urandom_range(0, 255)), 1'b0, 0, 0);
      vectors++; if (rd_valid !== 1'b1 || rd_data !== 16'h0000) begin
        miscompares++; $display("FAIL mid_zero[%0d]: got valid=%b data=%h expected valid=1 data=0000", i, rd_valid, rd_data);
      end
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_saturation();
    test_read_clear();
    test_arbitration();
    test_random();
    test_clear_all();
    test_reset_mid_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
